// File: rtl/idmem_arbiter.sv
// ---------------------------------------------------------------------------
// idmem_arbiter
//
// Shares one single-port word memory between an instruction-fetch requester
// and a load/store requester. Each access runs IDLE -> ACC -> RESP: grant
// pulse, then one memory strobe cycle, then a response pulse to the owner.
// Load/store normally wins, but after MAX_LS_STREAK back-to-back load/store
// grants taken while a fetch was waiting, the fetch gets the next slot.
// Misaligned addresses (addr[1:0] != 0) never touch memory and come back
// with the owner's err flag set. Every output is a register.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   if_req/if_addr  : fetch request (held until if_gnt) and address
//   if_gnt          : fetch accepted (one-cycle pulse)
//   if_rvalid       : fetch response pulse, qualifies if_rdata/if_err
//   ls_req/ls_we    : load/store request (held until ls_gnt), 1 = store
//   ls_addr/ls_wdata: load/store address and store data
//   ls_gnt          : load/store accepted (one-cycle pulse)
//   ls_done         : load/store response pulse, qualifies ls_rdata/ls_err
//   mem_rw/mem_wr   : memory read / write strobes (never both high)
//   mem_addr        : memory address
//   mem_wdata       : memory write data
//   mem_rdata       : memory read data
// ---------------------------------------------------------------------------
module idmem_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MAX_LS_STREAK = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_done,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_err,
    output logic              mem_rw,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int STREAK_W = (MAX_LS_STREAK > 0) ? $clog2(MAX_LS_STREAK + 1) : 1;
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LS_STREAK);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state, state_next;
    logic [STREAK_W-1:0] streak, streak_next;
    logic                owner_ls, owner_ls_next;
    logic                acc_we, acc_we_next;
    logic [ADDR_W-1:0]   acc_addr, acc_addr_next;
    logic [DATA_W-1:0]   acc_wdata, acc_wdata_next;
    logic                acc_err, acc_err_next;

    logic              if_gnt_next, if_rvalid_next, if_err_next;
    logic [DATA_W-1:0] if_rdata_next;
    logic              ls_gnt_next, ls_done_next, ls_err_next;
    logic [DATA_W-1:0] ls_rdata_next;
    logic              mem_rw_next, mem_wr_next;
    logic [ADDR_W-1:0] mem_addr_next;
    logic [DATA_W-1:0] mem_wdata_next;

    logic ls_win, if_win;

    // The FSM state register. Reset drops straight back to IDLE from any
    // state, which is what aborts an in-flight access without a response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Load/store wins by default. It only yields when a fetch is actually
    // waiting and the streak counter is full; a full counter with no fetch
    // pending must not block load/store.
    always_comb begin
        ls_win = ls_req && !(if_req && (streak == STREAK_MAX));
        if_win = if_req && !ls_win;
    end

    // Next-state and next-output logic. Pulses and strobes default low so
    // each is high for exactly the one cycle its state asks for; data and
    // address registers default to holding, so the non-owner's rdata and
    // the memory bus keep their last values between accesses.
    always_comb begin
        state_next     = state;
        streak_next    = streak;
        owner_ls_next  = owner_ls;
        acc_we_next    = acc_we;
        acc_addr_next  = acc_addr;
        acc_wdata_next = acc_wdata;
        acc_err_next   = acc_err;
        if_gnt_next    = 1'b0;
        if_rvalid_next = 1'b0;
        if_err_next    = 1'b0;
        if_rdata_next  = if_rdata;
        ls_gnt_next    = 1'b0;
        ls_done_next   = 1'b0;
        ls_err_next    = 1'b0;
        ls_rdata_next  = ls_rdata;
        mem_rw_next    = 1'b0;
        mem_wr_next    = 1'b0;
        mem_addr_next  = mem_addr;
        mem_wdata_next = mem_wdata;

        case (state)
            IDLE: begin
                if (ls_win) begin
                    ls_gnt_next    = 1'b1;
                    owner_ls_next  = 1'b1;
                    acc_we_next    = ls_we;
                    acc_addr_next  = ls_addr;
                    acc_wdata_next = ls_wdata;
                    if (if_req && (streak != STREAK_MAX)) begin
                        streak_next = streak + STREAK_W'(1);
                    end
                    state_next = ACC;
                end else if (if_win) begin
                    if_gnt_next   = 1'b1;
                    owner_ls_next = 1'b0;
                    acc_we_next   = 1'b0;
                    acc_addr_next = if_addr;
                    streak_next   = '0;
                    state_next    = ACC;
                end
            end
            ACC: begin
                // A misaligned access leaves the bus untouched and only
                // records the error for the response cycle.
                if (acc_addr[1:0] == 2'b00) begin
                    acc_err_next  = 1'b0;
                    mem_addr_next = acc_addr;
                    if (acc_we) begin
                        mem_wr_next    = 1'b1;
                        mem_wdata_next = acc_wdata;
                    end else begin
                        mem_rw_next = 1'b1;
                    end
                end else begin
                    acc_err_next = 1'b1;
                end
                state_next = RESP;
            end
            RESP: begin
                if (owner_ls) begin
                    ls_done_next  = 1'b1;
                    ls_err_next   = acc_err;
                    ls_rdata_next = mem_rdata;
                end else begin
                    if_rvalid_next = 1'b1;
                    if_err_next    = acc_err;
                    if_rdata_next  = mem_rdata;
                end
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath and output registers, all cleared by reset so nothing from an
    // aborted access leaks out afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            streak    <= '0;
            owner_ls  <= 1'b0;
            acc_we    <= 1'b0;
            acc_addr  <= '0;
            acc_wdata <= '0;
            acc_err   <= 1'b0;
            if_gnt    <= 1'b0;
            if_rvalid <= 1'b0;
            if_err    <= 1'b0;
            if_rdata  <= '0;
            ls_gnt    <= 1'b0;
            ls_done   <= 1'b0;
            ls_err    <= 1'b0;
            ls_rdata  <= '0;
            mem_rw    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            streak    <= streak_next;
            owner_ls  <= owner_ls_next;
            acc_we    <= acc_we_next;
            acc_addr  <= acc_addr_next;
            acc_wdata <= acc_wdata_next;
            acc_err   <= acc_err_next;
            if_gnt    <= if_gnt_next;
            if_rvalid <= if_rvalid_next;
            if_err    <= if_err_next;
            if_rdata  <= if_rdata_next;
            ls_gnt    <= ls_gnt_next;
            ls_done   <= ls_done_next;
            ls_err    <= ls_err_next;
            ls_rdata  <= ls_rdata_next;
            mem_rw    <= mem_rw_next;
            mem_wr    <= mem_wr_next;
            mem_addr  <= mem_addr_next;
            mem_wdata <= mem_wdata_next;
        end
    end

endmodule
